mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Shares one 2:1 mux output channel between two requesters, using round-robin arbitration and bounded bursts.
- Drives the mux select and the per-requester grants, and presents one valid/ready stream downstream.
- Sits in front of the mux2_1-style datapath; this block is the only owner of the select line.

Parameters:
WIDTH, 8, data width of each requester input and of the output.
MAX_BURST, 4, maximum accepted beats per grant before a forced re-arbitration (>=1).
CNT_W, 3, beat counter width; must hold MAX_BURST-1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
req0  input  1  requester 0 has data.
req1  input  1  requester 1 has data.
din0  input  WIDTH  requester 0 data.
din1  input  WIDTH  requester 1 data.
out_ready  input  1  downstream accepts a beat.
gnt0  output  1  registered; requester 0 owns the channel.
gnt1  output  1  registered; requester 1 owns the channel.
sel  output  1  registered mux select; 0=din0, 1=din1.
out_valid  output  1  combinational; (gnt0&req0)|(gnt1&req1).
out_data  output  WIDTH  combinational; sel ? din1 : din0.
out_last  output  1  combinational; out_valid & beat counter == MAX_BURST-1.

Behaviour:
- Reset, on a clk edge with rst_n=0:
  - state=IDLE, gnt0=gnt1=0, sel=0, beat counter=0.
  - last-winner pointer=1, so requester 0 wins the first tie.
  - Reset overrides everything, including mid-burst; no beat is accepted in the reset cycle.
- States are IDLE, G0 and G1. gnt0=(state==G0), gnt1=(state==G1). gnt0 and gnt1 are never both 1.
- sel: 0 in G0; 1 in G1; holds its previous value in IDLE.
- A transfer is out_valid & out_ready in the same cycle.
- IDLE:
  - no req: stay in IDLE.
  - exactly one req: go to that requester's G state.
  - both req: go to G of the requester that is not the last winner.
  - Latency: req seen in IDLE -> gnt high on the next edge. The first beat can transfer in that grant cycle.
- Gx, x = current owner, y = other requester:
  - On a transfer: counter increments.
  - Release occurs when either condition holds:
    - a transfer happens with counter==MAX_BURST-1; or
    - reqx==0 while in Gx, i.e. the owner withdrew (no transfer occurs that cycle).
  - On release: last winner=x and counter=0. Next state:
    - Gy if reqy=1;
    - else Gx if reqx=1 (burst limit reached, no contender);
    - else IDLE.
  - Switching Gx->Gy is a direct transition with no IDLE bubble.
  - Otherwise stay in Gx and hold the counter while out_ready=0.
- Requester protocol: a requester keeps din stable while req&gnt&~out_ready. It may drop req only after a transfer; it observes acceptance as gnt & out_ready.
- A req from the non-owner during a burst has no effect until release. Starvation is bounded to MAX_BURST beats.
- MAX_BURST=1: release after every beat, giving strict alternation under contention.
- Counter wrap cannot occur: it is reset on every release.
- out_data follows din combinationally through sel. No data register in this block.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, sel=0, out_valid=0. Release rst_n -> next edge gnt0=1, sel=0.
2. Single requester: req0=1, din0=8'hA5, out_ready=1 steady, MAX_BURST=4 -> 4 beats of A5, out_last on the 4th. G0 is re-granted with no gap (no contender). Counter restarts at 0.
3. Contention: req0=req1=1, out_ready=1, din0=8'h11, din1=8'h22 -> four beats of 11, then four beats of 22, then 11 again. sel toggles on the edge after each out_last, with no idle cycle.
4. Backpressure: in G1 with out_ready=0 for 3 cycles -> out_valid=1, out_data=din1 stable, counter unchanged. Raise out_ready -> beats resume, and out_last still lands on the 4th accepted beat.
5. Early withdrawal: in G0 after 2 beats, req0 drops while req1=1 -> next edge gnt1=1, sel=1. With only req0 later, G0 is granted (pointer=0 makes requester 1 win the next tie).
6. Mid-burst reset: rst_n=0 during G1, beat 3 -> next edge state=IDLE, gnt1=0, sel=0. After release with both requesting, requester 0 is granted first.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 2:1 mux; a grant lasts up to MAX_BURST beats.
// Latency: grant registered one edge after req; data/valid/last are combinational. A stalled out_ready holds the owner and its counter.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;

  logic xfer;
  logic burst_end;

  assign gnt0      = (state_q == G0);
  assign gnt1      = (state_q == G1);
  assign sel       = sel_q;
  assign out_valid = (gnt0 & req0) | (gnt1 & req1);
  assign out_data  = sel_q ? din1 : din0;
  assign out_last  = out_valid & (cnt_q == CNT_LAST);
  assign xfer      = out_valid & out_ready;
  assign burst_end = xfer & (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time gets the channel.
        if (req0 && req1) state_d = last_q ? G0 : G1;
        else if (req0)    state_d = G0;
        else if (req1)    state_d = G1;
      end
      G0: begin
        if (burst_end || !req0) begin
          last_d = 1'b0;
          cnt_d  = '0;
          if (req1)      state_d = G1;
          else if (req0) state_d = G0;
          else           state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      G1: begin
        if (burst_end || !req1) begin
          last_d = 1'b1;
          cnt_d  = '0;
          if (req0)      state_d = G0;
          else if (req1) state_d = G1;
          else           state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select follows the next owner and keeps its last value while idle.
  always_comb begin
    sel_d = sel_q;
    if (state_d == G0)      sel_d = 1'b0;
    else if (state_d == G1) sel_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed vector bench for mux2_rr_arbiter: each row gives one cycle's inputs and the outputs expected in that cycle.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] din0, din1;
  logic       out_ready;
  logic       gnt0, gnt1, sel, out_valid, out_last;
  logic [7:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .din0(din0), .din1(din1), .out_ready(out_ready),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  typedef struct {
    bit       rst_n, r0, r1;
    bit [7:0] d0, d1;
    bit       rdy;
    bit       g0, g1, sl, vld;
    bit [7:0] dat;
    bit       lst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rs, bit r0, bit r1, bit [7:0] d0, bit [7:0] d1, bit rdy,
                              bit g0, bit g1, bit sl, bit vld, bit [7:0] dat, bit lst);
    vec_t v;
    v.rst_n = rs; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
    v.g0 = g0; v.g1 = g1; v.sl = sl; v.vld = vld; v.dat = dat; v.lst = lst;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Grants must be mutually exclusive at all times once out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
        bad++;
        $display("FAIL gnt_exclusive: gnt0=%b gnt1=%b required not both 1", gnt0, gnt1);
      end
    end
  end

  initial begin
    int n;
    // reset, release, contention 11/22 with backpressure in G1
    vecs.push_back(mk(0,1,1,8'h11,8'h22,1, 0,0,0,0,8'h11,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,0,0,0,8'h11,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 1,0,0,1,8'h11,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 1,0,0,1,8'h11,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 1,0,0,1,8'h11,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 1,0,0,1,8'h11,1));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,1,1,1,8'h22,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,0, 0,1,1,1,8'h22,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,0, 0,1,1,1,8'h22,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,0, 0,1,1,1,8'h22,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,1,1,1,8'h22,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,1,1,1,8'h22,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,1,1,1,8'h22,1));
    // back to 11, then early withdrawal after two beats
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 1,0,0,1,8'h11,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 1,0,0,1,8'h11,0));
    vecs.push_back(mk(1,0,1,8'h11,8'h22,1, 1,0,0,0,8'h11,0));
    vecs.push_back(mk(1,0,1,8'h11,8'h22,1, 0,1,1,1,8'h22,0));
    vecs.push_back(mk(1,0,0,8'h11,8'h22,1, 0,1,1,0,8'h22,0));
    // idle holds sel=1, then lone req0, then tie with pointer=0 goes to requester 1
    vecs.push_back(mk(1,0,0,8'h11,8'h22,1, 0,0,1,0,8'h22,0));
    vecs.push_back(mk(1,1,0,8'h11,8'h22,1, 0,0,1,0,8'h22,0));
    vecs.push_back(mk(1,1,0,8'h11,8'h22,1, 1,0,0,1,8'h11,0));
    vecs.push_back(mk(1,0,0,8'h11,8'h22,1, 1,0,0,0,8'h11,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,0,0,0,8'h11,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,1,1,1,8'h22,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,1,1,1,8'h22,0));
    // mid-burst reset on beat 3 of G1, requester 0 wins afterwards
    vecs.push_back(mk(0,1,1,8'h11,8'h22,1, 0,1,1,1,8'h22,0));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,0,0,0,8'h11,0));
    // single requester A5: two full bursts with no gap
    vecs.push_back(mk(1,1,0,8'hA5,8'h22,1, 1,0,0,1,8'hA5,0));
    vecs.push_back(mk(1,1,0,8'hA5,8'h22,1, 1,0,0,1,8'hA5,0));
    vecs.push_back(mk(1,1,0,8'hA5,8'h22,1, 1,0,0,1,8'hA5,0));
    vecs.push_back(mk(1,1,0,8'hA5,8'h22,1, 1,0,0,1,8'hA5,1));
    vecs.push_back(mk(1,1,0,8'hA5,8'h22,1, 1,0,0,1,8'hA5,0));
    vecs.push_back(mk(1,1,0,8'hA5,8'h22,1, 1,0,0,1,8'hA5,0));
    vecs.push_back(mk(1,1,0,8'hA5,8'h22,1, 1,0,0,1,8'hA5,0));
    vecs.push_back(mk(1,1,0,8'hA5,8'h22,1, 1,0,0,1,8'hA5,1));

    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    din0 = 8'h11; din1 = 8'h22; out_ready = 1'b1;
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; req0 = vecs[i].r0; req1 = vecs[i].r1;
      din0 = vecs[i].d0; din1 = vecs[i].d1; out_ready = vecs[i].rdy;
      #1;
      chk("gnt0",      i, {7'd0, gnt0},      {7'd0, vecs[i].g0});
      chk("gnt1",      i, {7'd0, gnt1},      {7'd0, vecs[i].g1});
      chk("sel",       i, {7'd0, sel},       {7'd0, vecs[i].sl});
      chk("out_valid", i, {7'd0, out_valid}, {7'd0, vecs[i].vld});
      chk("out_data",  i, out_data,          vecs[i].dat);
      chk("out_last",  i, {7'd0, out_last},  {7'd0, vecs[i].lst});
    end

    // Contender arrives at the start of a fresh G0 burst: must wait exactly 4 beats.
    @(posedge clk);
    #1;
    req1 = 1'b1;
    n = 0;
    while (gnt1 !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("starve_bound_edges", 100, 8'(n), 8'd4);
    chk("switch_sel", 100, {7'd0, sel}, 8'd1);
    chk("switch_data", 100, out_data, 8'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
